// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the result-broadcast arbiter: tag width, source count/indices, FIFO sizing.
// No logic lives here; latency and backpressure are defined by the modules that import it.
// Source indices fix the priority order used when the scan starts at zero.
package cdb_arbiter_pkg;
    localparam int ROB_BITS      = 4;
    localparam int CDB_SRC_NUM   = 3;
    localparam int CDB_FIFO_BITS = 1;

    typedef enum logic [1:0] {
        CDB_SRC_ALU = 2'd0,
        CDB_SRC_LSB = 2'd1,
        CDB_SRC_BR  = 2'd2
    } cdb_src_e;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of source-side result handshakes and the two registered broadcast channels.
// Pure wiring; no latency of its own.
// Sources see src_ready per FIFO; the broadcast side has no backpressure.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int SRC_NUM = CDB_SRC_NUM,
    parameter int ID_BITS = ROB_BITS
) ();
    logic [SRC_NUM-1:0]         src_valid;
    logic [SRC_NUM*ID_BITS-1:0] src_id;
    logic [SRC_NUM*32-1:0]      src_value;
    logic [SRC_NUM-1:0]         src_ready;
    logic                       cdb1_rdy;
    logic [ID_BITS-1:0]         cdb1_id;
    logic [31:0]                cdb1_value;
    logic                       cdb2_rdy;
    logic [ID_BITS-1:0]         cdb2_id;
    logic [31:0]                cdb2_value;
    logic                       pending;

    // Sources plus broadcast consumers.
    modport master (
        output src_valid, src_id, src_value,
        input  src_ready, cdb1_rdy, cdb1_id, cdb1_value,
        input  cdb2_rdy, cdb2_id, cdb2_value, pending
    );

    // The arbiter itself.
    modport slave (
        input  src_valid, src_id, src_value,
        output src_ready, cdb1_rdy, cdb1_id, cdb1_value,
        output cdb2_rdy, cdb2_id, cdb2_value, pending
    );
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO, depth 1<<FIFO_BITS, head always visible combinationally.
// Latency: an entry pushed at one edge is at the head for the following cycle.
// Backpressure: full is registered-count only; push while full and pop while empty are ignored.
module cdb_src_fifo #(
    parameter int DATA_W    = 36,
    parameter int FIFO_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_W-1:0]    din,
    output logic [DATA_W-1:0]    head,
    output logic [FIFO_BITS:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int DEPTH = 1 << FIFO_BITS;

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DATA_W-1:0]    mem_d [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_BITS:0]   cnt_q, cnt_d;
    logic                 do_push, do_pop;

    assign full    = (cnt_q == (FIFO_BITS+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; flush and reset both empty the FIFO and drop a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; stale slots are never read while the count says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Shares two registered result-broadcast channels among SRC_NUM buffered sources (CDB_FIXED_PRIO_EN: fixed priority).
// Latency: push at edge E0 is broadcast at the earliest after edge E0+1; no empty-FIFO bypass.
// Backpressure: src_ready[i] drops when FIFO i is full; rdy_in low freezes every register.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int SRC_NUM   = CDB_SRC_NUM,
    parameter int FIFO_BITS = CDB_FIFO_BITS,
    parameter int ID_BITS   = ROB_BITS
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_in,
    cdb_arbiter_if.slave  bus
);
    localparam int ENT_W = ID_BITS + 32;
    localparam int PTR_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(SRC_NUM - 1);

    typedef struct packed {
        logic               rdy;
        logic [ID_BITS-1:0] id;
        logic [31:0]        value;
    } bcast_t;

    logic [ENT_W-1:0]   head  [SRC_NUM];
    logic [FIFO_BITS:0] count [SRC_NUM];
    logic [SRC_NUM-1:0] full, empty, push, pop;
    logic               g1_vld, g2_vld;
    logic [PTR_W-1:0]   g1_idx, g2_idx, scan_idx;
    bcast_t             cdb1_q, cdb1_d, cdb2_q, cdb2_d;
    logic               any_cnt;

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
        assign push[i]          = rdy_in & bus.src_valid[i] & ~full[i];
        assign bus.src_ready[i] = ~full[i];

        cdb_src_fifo #(
            .DATA_W    (ENT_W),
            .FIFO_BITS (FIFO_BITS)
        ) u_fifo (
            .clk   (clk_in),
            .rst   (rst_in),
            .clear (clear_in),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({bus.src_id[i*ID_BITS +: ID_BITS], bus.src_value[i*32 +: 32]}),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

`ifndef CDB_FIXED_PRIO_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Scan from the start source with wraparound; first two non-empty FIFOs win the channels.
    always_comb begin
        g1_vld = 1'b0;
        g2_vld = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
`ifdef CDB_FIXED_PRIO_EN
        scan_idx = '0;
`else
        scan_idx = rr_ptr_q;
`endif
        for (int k = 0; k < SRC_NUM; k++) begin
            if (!empty[scan_idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_idx = scan_idx;
                end
            end
            scan_idx = (scan_idx == LAST_SRC) ? '0 : scan_idx + 1'b1;
        end
    end

    // Pop the granted heads only on an active (unpaused) edge.
    always_comb begin
        pop = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            pop[i] = rdy_in & ((g1_vld & (g1_idx == PTR_W'(i))) |
                               (g2_vld & (g2_idx == PTR_W'(i))));
        end
    end

`ifndef CDB_FIXED_PRIO_EN
    // Next scan start is one past the last source granted; idle cycles leave it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rdy_in && g1_vld) begin
            if (g2_vld) begin
                rr_ptr_d = (g2_idx == LAST_SRC) ? '0 : g2_idx + 1'b1;
            end else begin
                rr_ptr_d = (g1_idx == LAST_SRC) ? '0 : g1_idx + 1'b1;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Load granted heads into the channels; ungranted channels go fully to zero.
    always_comb begin
        cdb1_d = cdb1_q;
        cdb2_d = cdb2_q;
        if (rdy_in) begin
            cdb1_d = g1_vld ? {1'b1, head[g1_idx]} : '0;
            cdb2_d = g2_vld ? {1'b1, head[g2_idx]} : '0;
        end
    end

    // Broadcast output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            cdb1_q <= '0;
            cdb2_q <= '0;
        end else begin
            cdb1_q <= cdb1_d;
            cdb2_q <= cdb2_d;
        end
    end

    // Any buffered entry anywhere keeps pending high.
    always_comb begin
        any_cnt = 1'b0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (count[i] != '0) begin
                any_cnt = 1'b1;
            end
        end
    end

    assign bus.pending    = any_cnt | cdb1_q.rdy | cdb2_q.rdy;
    assign bus.cdb1_rdy   = cdb1_q.rdy;
    assign bus.cdb1_id    = cdb1_q.id;
    assign bus.cdb1_value = cdb1_q.value;
    assign bus.cdb2_rdy   = cdb2_q.rdy;
    assign bus.cdb2_id    = cdb2_q.id;
    assign bus.cdb2_value = cdb2_q.value;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed corner sequences, random traffic vs a queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Sources hold valid/id/value while the model says the offer was not taken.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS    = CDB_SRC_NUM;
    localparam int IDB   = ROB_BITS;
    localparam int DEPTH = 1 << CDB_FIFO_BITS;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clear_in;
    logic [NS-1:0]  vld;
    logic [IDB-1:0] sid  [NS];
    logic [31:0]    sval [NS];

    cdb_arbiter_if #(.SRC_NUM(NS), .ID_BITS(IDB)) bus ();

    cdb_arbiter #(
        .SRC_NUM   (NS),
        .FIFO_BITS (CDB_FIFO_BITS),
        .ID_BITS   (IDB)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    always_comb begin
        bus.src_valid = vld;
        for (int i = 0; i < NS; i++) begin
            bus.src_id[i*IDB +: IDB] = sid[i];
            bus.src_value[i*32 +: 32] = sval[i];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: plain queues ----------------
    typedef struct { logic [IDB-1:0] id; logic [31:0] val; } ent_t;
    typedef struct { logic rdy; logic [IDB-1:0] id; logic [31:0] val; } out_t;

    ent_t        mq [NS][$];
    out_t        mo [2];
    int          mrr = 0;
    logic [NS-1:0] took = '0;
    logic [31:0] seen [$];

    task automatic model_step();
        int g[$];
        int start;
        int s;
        ent_t e;
        for (int i = 0; i < NS; i++)
            took[i] = vld[i] && (mq[i].size() < DEPTH) && rdy_in && !rst_in && !clear_in;
        if (rst_in || clear_in) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            mrr = 0;
            for (int c = 0; c < 2; c++) mo[c] = '{rdy: 1'b0, id: '0, val: '0};
            return;
        end
        if (!rdy_in) return;
`ifdef CDB_FIXED_PRIO_EN
        start = 0;
`else
        start = mrr;
`endif
        for (int k = 0; k < NS; k++) begin
            s = (start + k) % NS;
            if (mq[s].size() > 0 && g.size() < 2) g.push_back(s);
        end
        for (int c = 0; c < 2; c++) begin
            if (c < g.size()) begin
                e = mq[g[c]].pop_front();
                mo[c] = '{rdy: 1'b1, id: e.id, val: e.val};
            end else begin
                mo[c] = '{rdy: 1'b0, id: '0, val: '0};
            end
        end
        if (g.size() > 0) mrr = (g[g.size()-1] + 1) % NS;
        for (int i = 0; i < NS; i++)
            if (took[i]) mq[i].push_back('{id: sid[i], val: sval[i]});
    endtask

    // One clock: check ready before the edge, advance model, check outputs after it.
    task automatic tick();
        logic [NS-1:0] exp_rdy;
        logic          exp_pend;
        #2;
        for (int i = 0; i < NS; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
        chk("m_src_ready", 64'(bus.src_ready), 64'(exp_rdy));
        model_step();
        @(posedge clk_in);
        #1;
        exp_pend = mo[0].rdy | mo[1].rdy;
        for (int i = 0; i < NS; i++) if (mq[i].size() > 0) exp_pend = 1'b1;
        chk("m_cdb1", 64'({bus.cdb1_rdy, bus.cdb1_id, bus.cdb1_value}), 64'({mo[0].rdy, mo[0].id, mo[0].val}));
        chk("m_cdb2", 64'({bus.cdb2_rdy, bus.cdb2_id, bus.cdb2_value}), 64'({mo[1].rdy, mo[1].id, mo[1].val}));
        chk("m_pending", 64'(bus.pending), 64'(exp_pend));
        if (bus.cdb1_rdy === 1'b1) seen.push_back(bus.cdb1_value);
        if (bus.cdb2_rdy === 1'b1) seen.push_back(bus.cdb2_value);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rst, clr, rdy;
        logic [2:0] v;
        logic [3:0] i0, i1, i2;
        logic [31:0] v0;
        logic e1r; logic [3:0] e1i; logic [31:0] e1v;
        logic e2r; logic [3:0] e2i;
        logic [2:0] esr; logic ep;
    } vec_t;

    function automatic vec_t row(logic rst, logic clr, logic rdy, logic [2:0] v,
                                 logic [3:0] i0, logic [3:0] i1, logic [3:0] i2, logic [31:0] v0,
                                 logic e1r, logic [3:0] e1i, logic [31:0] e1v,
                                 logic e2r, logic [3:0] e2i, logic [2:0] esr, logic ep);
        vec_t r;
        r.rst = rst; r.clr = clr; r.rdy = rdy; r.v = v;
        r.i0 = i0; r.i1 = i1; r.i2 = i2; r.v0 = v0;
        r.e1r = e1r; r.e1i = e1i; r.e1v = e1v;
        r.e2r = e2r; r.e2i = e2i; r.esr = esr; r.ep = ep;
        return r;
    endfunction

    vec_t tbl [$];
    vec_t t;
    int   n1;
    logic saw_full;
    logic [31:0] bp_ids [$];
    logic [31:0] flush_seen_dead;

    initial begin
        rst_in = 1'b1; clear_in = 1'b0; rdy_in = 1'b1; vld = '0;
        for (int i = 0; i < NS; i++) begin sid[i] = '0; sval[i] = '0; end
        @(posedge clk_in);
        #1;

        // reset, 10 idle cycles
        tbl.push_back(row(1,0,1,3'b000, 0,0,0, 32'h0,    0,0,32'h0,      0,0, 3'b111, 0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0, 0,0,32'h0, 0,0, 3'b111, 0));
        // single push: visible only in the cycle after the second edge
        tbl.push_back(row(0,0,1,3'b001, 5,0,0, 32'h1234, 0,0,32'h0,      0,0, 3'b111, 1));
        tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0,    1,5,32'h1234,   0,0, 3'b111, 1));
        tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0,    0,0,32'h0,      0,0, 3'b111, 0));
        // three simultaneous pushes from rr_ptr = 0
        tbl.push_back(row(1,0,1,3'b000, 0,0,0, 32'h0,    0,0,32'h0,      0,0, 3'b111, 0));
        tbl.push_back(row(0,0,1,3'b111, 1,2,3, 32'h11,   0,0,32'h0,      0,0, 3'b111, 1));
        tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0,    1,1,32'h11,     1,2, 3'b111, 1));
        tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0,    1,3,32'h1003,   0,0, 3'b111, 1));
        // pointer is back at 0: fresh src 0 beats src 2
        tbl.push_back(row(0,0,1,3'b101, 4,0,6, 32'h44,   0,0,32'h0,      0,0, 3'b111, 1));
        tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0,    1,4,32'h44,     1,6, 3'b111, 1));
        tbl.push_back(row(0,0,1,3'b000, 0,0,0, 32'h0,    0,0,32'h0,      0,0, 3'b111, 0));

        for (int n = 0; n < tbl.size(); n++) begin
            t = tbl[n];
            rst_in = t.rst; clear_in = t.clr; rdy_in = t.rdy; vld = t.v;
            sid[0] = t.i0; sid[1] = t.i1; sid[2] = t.i2;
            sval[0] = t.v0;
            sval[1] = 32'h1000 + {28'h0, t.i1};
            sval[2] = 32'h1000 + {28'h0, t.i2};
            tick();
            chk($sformatf("tbl%0d_cdb1", n), 64'({bus.cdb1_rdy, bus.cdb1_id, bus.cdb1_value}), 64'({t.e1r, t.e1i, t.e1v}));
            chk($sformatf("tbl%0d_cdb2", n), 64'({bus.cdb2_rdy, bus.cdb2_id}), 64'({t.e2r, t.e2i}));
            chk($sformatf("tbl%0d_src_ready", n), 64'(bus.src_ready), 64'(t.esr));
            chk($sformatf("tbl%0d_pending", n), 64'(bus.pending), 64'(t.ep));
        end
        rst_in = 1'b0; vld = '0;

        // backpressure on src 1 while src 0 / src 2 stay busy
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        seen.delete();
        n1 = 0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (!vld[0] || took[0]) begin
                vld[0] = (cyc < 16); sid[0] = 4'(cyc); sval[0] = 32'hA0A0_0000 + 32'(cyc);
            end
            if (!vld[2] || took[2]) begin
                vld[2] = (cyc < 16); sid[2] = 4'(cyc); sval[2] = 32'hC0C0_0000 + 32'(cyc);
            end
            if (!vld[1] || took[1]) begin
                if (n1 < 4) begin
                    vld[1] = 1'b1; sid[1] = 4'(8 + n1); sval[1] = 32'hB1B1_0000 + 32'(8 + n1); n1++;
                end else begin
                    vld[1] = 1'b0;
                end
            end
            if (bus.src_ready[1] === 1'b0) saw_full = 1'b1;
            tick();
        end
        vld = '0;
        foreach (seen[k]) if (seen[k][31:16] == 16'hB1B1) bp_ids.push_back(seen[k]);
        chk("bp_count", 64'(bp_ids.size()), 64'd4);
        for (int k = 0; k < bp_ids.size() && k < 4; k++)
            chk($sformatf("bp_order%0d", k), 64'(bp_ids[k][3:0]), 64'(8 + k));
`ifndef CDB_FIXED_PRIO_EN
        chk("bp_ready_dropped", 64'(saw_full), 64'd1);
`endif

        // flush with 4 entries buffered and a competing src 2 push
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        vld = 3'b111; sid[0] = 1; sid[1] = 2; sid[2] = 3;
        sval[0] = 32'h51; sval[1] = 32'h52; sval[2] = 32'h53; tick();
        sid[0] = 4; sid[1] = 5; sid[2] = 6;
        sval[0] = 32'h54; sval[1] = 32'h55; sval[2] = 32'h56; tick();
        vld = 3'b011; sid[0] = 7; sid[1] = 8; sval[0] = 32'h57; sval[1] = 32'h58; tick();
        seen.delete();
        clear_in = 1'b1; vld = 3'b100; sid[2] = 13; sval[2] = 32'hDEAD; tick();
        chk("flush_cdb_rdy", 64'({bus.cdb1_rdy, bus.cdb2_rdy}), 64'd0);
        chk("flush_pending", 64'(bus.pending), 64'd0);
        chk("flush_src_ready", 64'(bus.src_ready), 64'h7);
        clear_in = 1'b0; vld = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("flush_idle%0d", k), 64'({bus.cdb1_rdy, bus.cdb2_rdy, bus.pending}), 64'd0);
        end
        flush_seen_dead = 0;
        foreach (seen[k]) if (seen[k] == 32'hDEAD) flush_seen_dead++;
        chk("flush_no_bcast", 64'(flush_seen_dead), 64'd0);

        // pause while cdb1 shows id 7; a src 0 offer must wait for resume
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        vld = 3'b111; sid[0] = 7; sid[1] = 1; sid[2] = 2;
        sval[0] = 32'h70; sval[1] = 32'h1001; sval[2] = 32'h1002; tick();
        vld = '0; tick();
        chk("pause_pre_cdb1", 64'({bus.cdb1_rdy, bus.cdb1_id, bus.cdb1_value}), 64'({1'b1, 4'd7, 32'h70}));
        vld[0] = 1'b1; sid[0] = 9; sval[0] = 32'h90; rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pause%0d_cdb1", k), 64'({bus.cdb1_rdy, bus.cdb1_id, bus.cdb1_value}), 64'({1'b1, 4'd7, 32'h70}));
            chk($sformatf("pause%0d_cdb2", k), 64'({bus.cdb2_rdy, bus.cdb2_id, bus.cdb2_value}), 64'({1'b1, 4'd1, 32'h1001}));
            chk($sformatf("pause%0d_ready_pend", k), 64'({bus.src_ready, bus.pending}), 64'({3'b111, 1'b1}));
        end
        rdy_in = 1'b1; tick();
        chk("resume_cdb1", 64'({bus.cdb1_rdy, bus.cdb1_id, bus.cdb1_value}), 64'({1'b1, 4'd2, 32'h1002}));
        chk("resume_cdb2_rdy", 64'(bus.cdb2_rdy), 64'd0);
        vld = '0; tick();
        chk("resume_held_push", 64'({bus.cdb1_rdy, bus.cdb1_id, bus.cdb1_value}), 64'({1'b1, 4'd9, 32'h90}));
        tick();
        chk("resume_drained", 64'(bus.pending), 64'd0);

        // random traffic against the queue model
        for (int cyc = 0; cyc < 600; cyc++) begin
            clear_in = ($urandom_range(0, 39) == 0);
            rdy_in   = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < NS; i++) begin
                if (!vld[i] || took[i]) begin
                    vld[i]  = ($urandom_range(0, 2) != 0);
                    sid[i]  = 4'($urandom_range(0, 15));
                    sval[i] = $urandom;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
